// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram
// Brief    : Single-port word-addressed synchronous data memory with a
//            zero-fill sweep after reset and registered, write-through output.
// Revision : 1.0
// ============================================================================
module data_ram #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  WRITE_ENABLE,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  BUSY
);

    localparam int                  c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t c_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= c_RESET_STATE;
            ptr_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // During the sweep the write port is stolen by the clear pointer, so
    // host accesses are dropped and the output is held at zero.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        mem_addr   = ADDRESS;
        mem_wdata  = DATA_IN;
        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_addr   = ptr_q;
                mem_wdata  = '0;
                ptr_d      = ptr_q + 1'b1;
                data_out_d = '0;
                if (ptr_q == c_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (WRITE_ENABLE) begin
                    mem_we     = 1'b1;
                    data_out_d = DATA_IN;
                end else begin
                    data_out_d = mem_q[ADDRESS];
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign DATA_OUT = data_out_q;
    assign BUSY     = (state_q == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram
// Brief    : Self-checking scoreboard bench for data_ram (default geometry).
// Revision : 1.0
// ============================================================================
module tb_data_ram;

    localparam int c_AW    = 10;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 2 ** c_AW;

    logic            clk;
    logic            rst_n;
    logic [c_AW-1:0] address;
    logic [c_DW-1:0] data_in;
    logic            write_enable;
    logic [c_DW-1:0] data_out;
    logic            busy;

    data_ram #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .ADDRESS      (address),
        .DATA_IN      (data_in),
        .WRITE_ENABLE (write_enable),
        .DATA_OUT     (data_out),
        .BUSY         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [c_DW-1:0] model [c_DEPTH];
    logic [c_DW-1:0] exp_q [$];
    int              n_checks = 0;
    int              n_pass   = 0;

    task automatic check_eq(input string tag, input logic [c_DW-1:0] got,
                            input logic [c_DW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_DEPTH; i++) model[i] = '0;
    endtask

    // One host access: expected value is queued when driven, popped after the edge.
    task automatic access(input string tag, input logic we,
                          input logic [c_AW-1:0] addr, input logic [c_DW-1:0] din);
        logic [c_DW-1:0] exp;
        @(negedge clk);
        write_enable = we;
        address      = addr;
        data_in      = din;
        if (we) begin
            model[addr] = din;
            exp_q.push_back(din);
        end else begin
            exp_q.push_back(model[addr]);
        end
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_eq(tag, data_out, exp);
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    // Counts edges from reset release until BUSY drops; the sweep must take DEPTH edges.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (n < c_DEPTH + 64) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check_eq({tag, "_dout_busy"}, data_out, '0);
            if (!busy) break;
        end
        check_eq({tag, "_sweep_cycles"}, n, c_DEPTH);
    endtask

    initial begin
        rst_n        = 1'b0;
        address      = '0;
        data_in      = '0;
        write_enable = 1'b0;
        model_clear();

        #1;
        check_eq("rst_dout", data_out, '0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);

        // Release reset and hammer a write at addr 3 for the whole sweep.
        rst_n        = 1'b1;
        write_enable = 1'b1;
        address      = 10'd3;
        data_in      = 32'd99;
        wait_ready("sweep0");
        @(negedge clk);
        write_enable = 1'b0;

        access("rd5_after_sweep", 1'b0, 10'd5, '0);
        access("rd3_busy_write_ignored", 1'b0, 10'd3, '0);

        access("wr1_24", 1'b1, 10'd1, 32'd24);
        access("wr2_61", 1'b1, 10'd2, 32'd61);
        access("rd1", 1'b0, 10'd1, '0);
        access("rd2", 1'b0, 10'd2, '0);
        access("wr2_62", 1'b1, 10'd2, 32'd62);
        access("rd2_new", 1'b0, 10'd2, '0);
        access("rd1_kept", 1'b0, 10'd1, '0);

        access("wr1023", 1'b1, 10'd1023, 32'hDEAD_BEEF);
        access("wr0", 1'b1, 10'd0, 32'h0000_0001);
        access("rd1023", 1'b0, 10'd1023, '0);
        access("rd0", 1'b0, 10'd0, '0);
        access("rd511", 1'b0, 10'd511, '0);
        access("rd512", 1'b0, 10'd512, '0);

        for (int i = 0; i < 24; i++) begin
            access("rand_wr", 1'b1, c_AW'($urandom_range(0, c_DEPTH - 1)), $urandom);
            access("rand_rd", 1'b0, c_AW'($urandom_range(0, c_DEPTH - 1)), '0);
        end
        for (int i = 0; i < c_DEPTH; i += 97) begin
            access("scan_rd", 1'b0, c_AW'(i), '0);
        end

        // Asynchronous reset between edges after non-zero data has been read.
        access("rd1023_pre_rst", 1'b0, 10'd1023, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout", data_out, '0);
        check_eq("async_rst_busy", {31'd0, busy}, 32'd1);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep1");
        access("rd2_after_rst", 1'b0, 10'd2, '0);
        access("rd1023_after_rst", 1'b0, 10'd1023, '0);

        // Reset in the middle of a sweep restarts the full sweep.
        access("wr7", 1'b1, 10'd7, 32'h1234_5678);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midsweep_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep2");
        access("rd7_after_midsweep", 1'b0, 10'd7, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
